// File: rtl/pixel_out_packer.sv
// Packs groups of 14-bit RGB pixels into OUT_BYTES-wide words (8- or 16-bit components).
// Optional feature macro: PIXEL_OUT_PACKER_CHECKSUM_EN (frame byte checksum).
module pixel_out_packer #(
  parameter int NBR_PIXS  = 4,
  parameter int OUT_BYTES = 32
) (
  input  logic                           clk_out_int,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           comp_16bit,
  input  logic [NBR_PIXS*3*14-1:0]       pixs_in,
  input  logic                           pixs_in_valid,
  input  logic                           pixs_in_eof,
  output logic                           in_ready,
  output logic [OUT_BYTES*8-1:0]         out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic [$clog2(OUT_BYTES+1)-1:0] out_bytes,
  output logic [31:0]                    pixel_count,
  output logic [31:0]                    frame_checksum
);

  localparam int GRP_BYTES = NBR_PIXS * 6;
  localparam int CAP       = OUT_BYTES + GRP_BYTES;
  localparam int AW        = CAP * 8;
  localparam int FW        = $clog2(CAP + 1);
  localparam int BW        = $clog2(OUT_BYTES + 1);
  localparam logic [FW-1:0] OUT_F = FW'(OUT_BYTES);
  localparam logic [FW-1:0] G8    = FW'(NBR_PIXS * 3);
  localparam logic [FW-1:0] G16   = FW'(NBR_PIXS * 6);

  generate
    if (OUT_BYTES < NBR_PIXS * 6) begin : g_bad_cfg
      $error("pixel_out_packer: OUT_BYTES must be >= NBR_PIXS*6");
    end
  endgenerate

  typedef enum logic [1:0] {ACTIVE, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [AW-1:0]          acc, acc_nxt;
  logic [FW-1:0]          fill, fill_nxt;
  logic [FW-1:0]          grp_len, take;
  logic [GRP_BYTES*8-1:0] grp;
  logic [13:0]            comp;
  logic                   mode_q, mode_eff, empty, rdy_en;
  logic                   accept, handoff, word_avail, valid_nxt;

  // The presented word lives in the low bytes of the accumulator; bytes at or above fill are always zero.
  assign out_data  = acc[OUT_BYTES*8-1:0];
  assign out_bytes = !out_valid ? '0 : (fill >= OUT_F) ? BW'(OUT_BYTES) : BW'(fill);
  assign empty     = (fill == '0) && !out_valid;
  assign mode_eff  = empty ? comp_16bit : mode_q;
  assign handoff   = out_valid & out_ready;
  assign accept    = pixs_in_valid & in_ready & ~flush & (state == ACTIVE);
  assign grp_len   = mode_eff ? G16 : G8;
  assign take      = FW'(out_bytes);

  always_comb begin
    grp  = '0;
    comp = '0;
    if (mode_eff) begin
      for (int i = 0; i < NBR_PIXS * 3; i++) begin
        comp = pixs_in[i*14 +: 14];
        grp[i*16 +: 8]   = {2'b00, comp[13:8]};
        grp[i*16+8 +: 8] = comp[7:0];
      end
    end else begin
      for (int i = 0; i < NBR_PIXS * 3; i++) begin
        grp[i*8 +: 8] = pixs_in[i*14 +: 8];
      end
    end
  end

  always_comb begin
    acc_nxt  = acc;
    fill_nxt = fill;
    if (handoff) begin
      acc_nxt  = acc >> (OUT_BYTES * 8);
      fill_nxt = fill - take;
    end
    if (accept) begin
      acc_nxt  = acc_nxt | (AW'(grp) << {fill_nxt, 3'b000});
      fill_nxt = fill_nxt + grp_len;
    end
  end

  always_comb begin
    word_avail = ((state_nxt == ACTIVE) && (fill_nxt >= OUT_F)) ||
                 ((state_nxt == DRAIN) && (fill_nxt != '0));
    valid_nxt  = (out_valid & ~out_ready) | word_avail;
  end

  // state    | meaning
  // ACTIVE   | accepting groups, emitting full words
  // DRAIN    | eof seen: emit remaining words, last one flagged
  // DONE     | frame finished, groups dropped until flush
  always_ff @(posedge clk_out_int) begin
    if (!rst_n || flush) state <= ACTIVE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACTIVE:  if (accept && pixs_in_eof) state_nxt = DRAIN;
      DRAIN:   if (handoff && out_last)   state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = ACTIVE;
    endcase
  end

  always_comb begin
    in_ready = rdy_en & (((state == ACTIVE) & ((fill < OUT_F) | handoff)) | (state == DONE));
    out_last = out_valid & (state == DRAIN) & (fill <= OUT_F);
  end

  always_ff @(posedge clk_out_int) begin
    if (!rst_n) begin
      acc         <= '0;
      fill        <= '0;
      out_valid   <= 1'b0;
      pixel_count <= '0;
      mode_q      <= 1'b0;
      rdy_en      <= 1'b0;
    end else if (flush) begin
      acc         <= '0;
      fill        <= '0;
      out_valid   <= 1'b0;
      pixel_count <= '0;
      rdy_en      <= 1'b1;
    end else begin
      acc       <= acc_nxt;
      fill      <= fill_nxt;
      out_valid <= valid_nxt;
      rdy_en    <= 1'b1;
      if (accept) pixel_count <= pixel_count + 32'(NBR_PIXS);
      if (empty)  mode_q      <= comp_16bit;
    end
  end

`ifdef PIXEL_OUT_PACKER_CHECKSUM_EN
  logic [31:0] word_sum, cksum;

  always_comb begin
    word_sum = '0;
    for (int k = 0; k < OUT_BYTES; k++) word_sum = word_sum + 32'(out_data[k*8 +: 8]);
  end

  always_ff @(posedge clk_out_int) begin
    if (!rst_n || flush) cksum <= '0;
    else if (handoff)    cksum <= cksum + word_sum;
  end

  assign frame_checksum = cksum;
`else
  assign frame_checksum = '0;
`endif

endmodule

// File: tb/tb_pixel_out_packer.sv
// Scoreboard bench for pixel_out_packer: byte-stream reference model, directed and random frames.
module tb_pixel_out_packer;
  localparam int NP = 4;
  localparam int OB = 32;
  localparam int PW = NP * 3 * 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0, flush = 1'b0, comp_16bit = 1'b0;
  logic [PW-1:0] pixs_in = '0;
  logic          pixs_in_valid = 1'b0, pixs_in_eof = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, out_last;
  logic [OB*8-1:0] out_data;
  logic [5:0]    out_bytes;
  logic [31:0]   pixel_count, frame_checksum;

  int compared = 0, mismatched = 0;
  int ready_mode = 1;

  // reference model: bytes of the current frame not yet handed off
  logic [7:0]  q[$];
  int          phase_m = 0;      // 0 accepting, 1 draining, 2 finished
  logic        mode_m = 1'b0;
  logic [31:0] pc_m = '0, cks_m = '0;
  bit          rdy_m = 0, prev_rst = 0, prev_stall = 0;
  logic [OB*8-1:0] prev_data;
  logic [5:0]  prev_bytes;
  logic        prev_last;

  pixel_out_packer #(.NBR_PIXS(NP), .OUT_BYTES(OB)) dut (
    .clk_out_int(clk), .rst_n(rst_n), .flush(flush), .comp_16bit(comp_16bit),
    .pixs_in(pixs_in), .pixs_in_valid(pixs_in_valid), .pixs_in_eof(pixs_in_eof),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_bytes(out_bytes),
    .pixel_count(pixel_count), .frame_checksum(frame_checksum));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom % 4) != 0;
    endcase
  end

  // monitor + model, sampled at negedge where all inputs/outputs are settled
  always @(negedge clk) begin
    bit handoff, empty_m, exp_valid, exp_rdy, last_e;
    int n;
    logic [255:0] ew;
    logic [31:0] s;
    logic [13:0] c;
    handoff = out_valid && out_ready;
    if (!rst_n && !prev_rst) begin
      chk("rst_out_valid", 256'(out_valid), 0);
      chk("rst_in_ready", 256'(in_ready), 0);
      chk("rst_out_data", 256'(out_data), 0);
      chk("rst_out_bytes_last", {out_bytes, out_last}, 0);
      chk("rst_pixel_count", 256'(pixel_count), 0);
      chk("rst_checksum", 256'(frame_checksum), 0);
    end else begin
      chk("pixel_count", 256'(pixel_count), 256'(pc_m));
      chk("frame_checksum", 256'(frame_checksum), 256'(cks_m));
      exp_valid = (phase_m == 0 && q.size() >= OB) || (phase_m == 1 && q.size() > 0);
      chk("out_valid", 256'(out_valid), 256'(exp_valid));
      exp_rdy = rdy_m && ((phase_m == 0 && (q.size() < OB || handoff)) || phase_m == 2);
      chk("in_ready", 256'(in_ready), 256'(exp_rdy));
      if (prev_stall)
        chk("stall_stable", {out_data, out_bytes, out_last}, {prev_data, prev_bytes, prev_last});
    end
    prev_stall = out_valid && !out_ready;
    prev_data = out_data; prev_bytes = out_bytes; prev_last = out_last;
    if (!rst_n || flush) begin
      q.delete(); pc_m = 0; cks_m = 0; phase_m = 0; prev_stall = 0;
      if (!rst_n) rdy_m = 0; else rdy_m = 1;
    end else begin
      empty_m = q.size() == 0;
      if (handoff) begin
        if (q.size() == 0) begin
          chk("unexpected_word", 256'(out_valid), 0);
        end else begin
          last_e = (phase_m == 1) && (q.size() <= OB);
          n = last_e ? q.size() : OB;
          ew = '0; s = 0;
          for (int k = 0; k < n; k++) begin
            ew[k*8 +: 8] = q.pop_front();
            s = s + 32'(ew[k*8 +: 8]);
          end
          chk("word_data", 256'(out_data), ew);
          chk("word_bytes", 256'(out_bytes), 256'(n));
          chk("word_last", 256'(out_last), 256'(last_e));
`ifdef PIXEL_OUT_PACKER_CHECKSUM_EN
          cks_m = cks_m + s;
`endif
          if (last_e) phase_m = 2;
        end
      end
      if (empty_m) mode_m = comp_16bit;
      if (pixs_in_valid && in_ready && phase_m == 0) begin
        for (int i = 0; i < NP * 3; i++) begin
          c = pixs_in[i*14 +: 14];
          if (mode_m) begin q.push_back({2'b00, c[13:8]}); q.push_back(c[7:0]); end
          else q.push_back(c[7:0]);
        end
        pc_m = pc_m + NP;
        if (pixs_in_eof) phase_m = 1;
      end
      rdy_m = 1;
    end
    prev_rst = rst_n;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send_group(input logic [PW-1:0] d, input logic e);
    bit acc = 0;
    int n = 0;
    pixs_in = d; pixs_in_eof = e; pixs_in_valid = 1'b1;
    while (!acc && n < 500) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end
    pixs_in_valid = 1'b0; pixs_in_eof = 1'b0;
    compared++;
    if (!acc) begin mismatched++; $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n); end
  endtask

  task automatic do_flush();
    flush = 1'b1; cyc(); flush = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (phase_m != 2 && n < 3000) begin cyc(); n++; end
    compared++;
    if (phase_m != 2) begin mismatched++; $display("FAIL drain_timeout: phase %0d after %0d cycles, required 2", phase_m, n); end
  endtask

  function automatic logic [PW-1:0] pat_seq(int g);
    logic [PW-1:0] r = '0;
    for (int i = 0; i < NP * 3; i++) r[i*14 +: 14] = 14'(16 * g + i);
    return r;
  endfunction

  function automatic logic [PW-1:0] pat_const(logic [13:0] v);
    logic [PW-1:0] r = '0;
    for (int i = 0; i < NP * 3; i++) r[i*14 +: 14] = v;
    return r;
  endfunction

  function automatic logic [PW-1:0] pat_rand();
    logic [PW-1:0] r = '0;
    for (int i = 0; i < NP * 3; i++) r[i*14 +: 14] = 14'($urandom);
    return r;
  endfunction

  initial begin
    int ng;
    bit no_eof;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // sequential components, 8-bit: inspect the first word directly
    ready_mode = 0; comp_16bit = 1'b0; cyc();
    for (int g = 0; g < 3; g++) send_group(pat_seq(g), 1'b0);
    @(negedge clk);
    chk("w0_byte0", 256'(out_data[7:0]), 256'h00);
    chk("w0_byte1", 256'(out_data[15:8]), 256'h01);
    chk("w0_byte12", 256'(out_data[103:96]), 256'h10);
    @(posedge clk); #1;
    ready_mode = 1;
    for (int g = 3; g < 8; g++) send_group(pat_seq(g), 1'b0);
    repeat (4) cyc();
    chk("seq_pixel_count", 256'(pixel_count), 256'd32);
    chk("seq_all_emitted", 256'(q.size()), 0);
    do_flush();

    // 16-bit constant components
    comp_16bit = 1'b1; cyc();
    for (int g = 0; g < 4; g++) send_group(pat_const(14'h1234), 1'b0);
    repeat (4) cyc();
    chk("c16_pixel_count", 256'(pixel_count), 256'd16);
    do_flush();

    // short frame with residual, then dropped groups
    comp_16bit = 1'b0; cyc();
    for (int g = 0; g < 3; g++) send_group(pat_rand(), g == 2);
    wait_done();
    for (int g = 0; g < 5; g++) send_group(pat_rand(), 1'b0);
    cyc();
    chk("drop_pixel_count", 256'(pixel_count), 256'd12);
    do_flush();

    // back-pressure for 10 cycles during a continuous stream
    fork
      for (int g = 0; g < 12; g++) send_group(pat_rand(), g == 11);
      begin repeat (3) cyc(); ready_mode = 0; repeat (10) cyc(); ready_mode = 1; end
    join
    wait_done();
    do_flush();

    // flush while a word is presented
    ready_mode = 0; cyc();
    for (int g = 0; g < 3; g++) send_group(pat_rand(), 1'b0);
    @(negedge clk);
    chk("pre_flush_valid", 256'(out_valid), 1);
    @(posedge clk); #1;
    do_flush();
    @(negedge clk);
    chk("post_flush_valid", 256'(out_valid), 0);
    chk("post_flush_count", 256'(pixel_count), 0);
    @(posedge clk); #1;
    ready_mode = 1;
    for (int g = 0; g < 3; g++) send_group(pat_seq(g + 40), g == 2);
    wait_done();
    do_flush();

`ifdef PIXEL_OUT_PACKER_CHECKSUM_EN
    comp_16bit = 1'b0; cyc();
    send_group(pat_const(14'd1), 1'b1);
    wait_done();
    repeat (2) cyc();
    chk("cks_value", 256'(frame_checksum), 256'd12);
    do_flush();
`endif

    // random frames
    for (int f = 0; f < 40; f++) begin
      comp_16bit = 1'($urandom);
      ready_mode = 1 + (f % 2);
      cyc();
      ng = 1 + ($urandom % 12);
      no_eof = (f % 7) == 3;
      for (int g = 0; g < ng; g++) begin
        repeat ($urandom % 3) cyc();
        send_group(pat_rand(), !no_eof && g == ng - 1);
      end
      if (!no_eof) wait_done();
      else repeat ($urandom % 5) cyc();
      do_flush();
    end

    // reset in the middle of a frame
    ready_mode = 0; comp_16bit = 1'b0; cyc();
    for (int g = 0; g < 3; g++) send_group(pat_rand(), 1'b0);
    rst_n = 1'b0; repeat (2) cyc();
    rst_n = 1'b1; ready_mode = 1;
    repeat (2) cyc();
    for (int g = 0; g < 3; g++) send_group(pat_rand(), g == 2);
    wait_done();
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1);
  end
endmodule

// File: doc/pixel_out_packer.md
PIXEL_OUT_PACKER -- requirements
Module: pixel_out_packer

Interface
REQ-001 SHALL have parameter NBR_PIXS, default 4: pixels per input group.
REQ-002 SHALL have parameter OUT_BYTES, default 32: bytes per output word. Elaboration fails if OUT_BYTES < NBR_PIXS*6.
REQ-003 SHALL have port clk_out_int, input, 1: single clock. All logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset. Synchronous, active-low.
REQ-005 SHALL have port flush, input, 1: synchronous frame restart.
REQ-006 SHALL have port comp_16bit, input, 1: 0 = 1 byte/component, 1 = 2 bytes/component. Sampled only while the packer is empty.
REQ-007 SHALL have port pixs_in, input, NBR_PIXS*3*14: component (p,c) at bits [(p*3+c)*14 +: 14].
REQ-008 SHALL have ports pixs_in_valid (input, 1), pixs_in_eof (input, 1) and in_ready (output, 1).
REQ-009 SHALL have ports out_data (output, OUT_BYTES*8), out_valid (output, 1), out_ready (input, 1) and out_last (output, 1).
REQ-010 SHALL have port out_bytes, output, $clog2(OUT_BYTES+1): number of meaningful bytes in out_data.
REQ-011 SHALL have ports pixel_count (output, 32) and frame_checksum (output, 32).

Function
REQ-012 Group accepted when pixs_in_valid & in_ready.
REQ-013 Accepted group appends bytes in order pixel 0..NBR_PIXS-1, component 0..2.
- 8-bit mode: comp[7:0].
- 16-bit mode: {2'b0, comp[13:0]}, high byte first.
REQ-014 Stream byte k of a word SHALL appear at out_data[8k +: 8].
REQ-015 Internal byte accumulator capacity = OUT_BYTES + NBR_PIXS*6.
- in_ready = 1 in state ACTIVE when fill < OUT_BYTES, or when a word is handed off in the same cycle.
REQ-016 When fill >= OUT_BYTES and not already presenting: out_valid rises the next cycle with the oldest OUT_BYTES bytes, out_bytes = OUT_BYTES, out_last = 0.
REQ-017 out_data, out_bytes and out_last SHALL hold stable while out_valid & ~out_ready.
- On handoff the remaining bytes shift down.
- Accept and handoff in the same cycle are legal and lossless.
REQ-018 State machine:
- ACTIVE: accepts groups.
- ACTIVE -> DRAIN: on accepting a group with pixs_in_eof = 1. That group is written.
- DRAIN: in_ready = 0; emits remaining full words, then one final word.
- Final word: out_last = 1, out_bytes = residual (1..OUT_BYTES), unused bytes zero.
- Residual = 0 at eof: the last full word carries out_last = 1.
- DRAIN -> DONE: on handoff of the last word.
- DONE: in_ready = 1, groups dropped silently, out_valid = 0.
- Any state -> ACTIVE: on flush.
REQ-019 pixel_count increments by NBR_PIXS per accepted (non-dropped) group. Wraps modulo 2^32.
REQ-020 Flush in any state, including with out_valid high: next cycle fill = 0, out_valid = 0, out_last = 0, pixel_count = 0, state ACTIVE. The pending word is discarded.
REQ-021 Flush and pixs_in_valid in the same cycle: flush wins, the group is not accepted.
REQ-022 Latency: first output word valid 1 cycle after the accept that makes fill >= OUT_BYTES.

Reset
REQ-023 While rst_n = 0 at a clock edge:
- out_valid = 0, out_last = 0, out_data = 0, out_bytes = 0.
- in_ready = 0, pixel_count = 0, frame_checksum = 0, fill = 0, state = ACTIVE.
- in_ready rises 1 cycle after rst_n goes high.
REQ-024 Reset asserted mid-frame SHALL behave like REQ-020 and additionally clear frame_checksum.

Configuration
REQ-025 Macro PIXEL_OUT_PACKER_CHECKSUM_EN:
- Defined: frame_checksum = 32-bit wrapping sum of all meaningful bytes handed off since the last flush or reset. Updates on the cycle after each handoff. Cleared by flush.
- Undefined: frame_checksum is tied to 0 and no adder logic is compiled.

Verification
REQ-026 8-bit, 8 groups, comp (p,c) = 16*g + 3*p + c, out_ready = 1 -> 3 words. Word 0: byte0 = 0x00, byte1 = 0x01, byte12 = 0x10. pixel_count = 32.
REQ-027 16-bit, all comps 14'h1234, 4 groups -> 3 words of repeating 0x12, 0x34. pixel_count = 16.
REQ-028 8-bit, 3 groups, eof on the third -> word 1: out_bytes = 32, out_last = 0; word 2: out_bytes = 4, out_last = 1, bytes 4..31 = 0. Then 5 further groups dropped; pixel_count stays 12.
REQ-029 out_ready = 0 for 10 cycles during a continuous input stream -> in_ready falls once fill >= 32, out_data stable, and every byte is later emitted exactly once, in order.
REQ-030 flush asserted with out_valid = 1 mid-frame -> next cycle out_valid = 0, pixel_count = 0; the next frame's first word contains only new-frame bytes.
REQ-031 With PIXEL_OUT_PACKER_CHECKSUM_EN, 8-bit, one group of all comps = 1 with eof -> final word out_bytes = 12, frame_checksum = 12.
